// File: rtl/axis_bram_adapter_v2_0_cntl.sv
// axis_bram_adapter_v2_0_cntl
//   Control core of the AXI-Stream <-> BRAM adapter. Moves whole lines of
//   WORDS_PER_LINE stream words between a narrow word stream and a wide BRAM
//   line. It steers the datapath line buffers via word-slot indices and
//   applies ready/valid backpressure on both stream sides.
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   start, rw           : transfer request (sampled in IDLE); rw=1 write, 0 read
//   start_index         : first BRAM line address
//   bound_index         : last BRAM line address (inclusive, wraps modulo 2^ADDR_W)
//   busy, done          : busy while not IDLE; done pulses once per transfer
//   s_valid/s_ready/s_tlast : input stream handshake
//   lbuf_load, lbuf_word_idx: capture stream word into line-buffer slot
//   m_valid/m_ready/m_tlast : output stream handshake
//   obuf_load, obuf_word_idx: capture BRAM data / select output word
//   bram_en, bram_we, bram_addr : BRAM port controls
//
// Build option
//   AXIS_BRAM_ADAPTER_IN_TLAST_EN : an accepted write beat with s_tlast=1
//   ends the transfer after committing the partial line. Undefined: s_tlast
//   is ignored.

module axis_bram_adapter_v2_0_cntl #(
  parameter int ADDR_W         = 12,
  parameter int WORDS_PER_LINE = 36,
  parameter int IDX_W          = 6,
  parameter int BRAM_RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] start_index,
  input  logic [ADDR_W-1:0] bound_index,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_tlast,
  output logic              lbuf_load,
  output logic [IDX_W-1:0]  lbuf_word_idx,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_tlast,
  output logic              obuf_load,
  output logic [IDX_W-1:0]  obuf_word_idx,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_FILL,
    S_WR_COMMIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_DRAIN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [1:0]       LAT_LAST = 2'(BRAM_RD_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] bound;
  logic [IDX_W-1:0]  cnt;
  logic [1:0]        lat;
  logic              early_end;
  logic              fill_stop;

`ifdef AXIS_BRAM_ADAPTER_IN_TLAST_EN
  assign fill_stop = s_tlast;
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast;
  assign fill_stop    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      bound     <= '0;
      cnt       <= '0;
      lat       <= '0;
      early_end <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= start_index;
            bound     <= bound_index;
            cnt       <= '0;
            early_end <= 1'b0;
            state     <= rw ? S_WR_FILL : S_RD_ISSUE;
          end
        end
        S_WR_FILL: begin
          if (s_valid) begin
            // A tlast beat (when enabled) closes the line early; the commit
            // then finishes the whole transfer regardless of bound.
            if (cnt == LAST_IDX || fill_stop) begin
              cnt       <= '0;
              early_end <= fill_stop;
              state     <= S_WR_COMMIT;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        S_WR_COMMIT: begin
          if (addr == bound || early_end) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= S_WR_FILL;
          end
        end
        S_RD_ISSUE: begin
          lat   <= '0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (lat == LAT_LAST) begin
            state <= S_RD_DRAIN;
          end else begin
            lat <= lat + 2'd1;
          end
        end
        S_RD_DRAIN: begin
          if (m_ready) begin
            if (cnt == LAST_IDX) begin
              cnt <= '0;
              if (addr == bound) begin
                state <= S_DONE;
              end else begin
                addr  <= addr + ADDR_W'(1);
                state <= S_RD_ISSUE;
              end
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of the registered state so they never glitch
  // with stream inputs (lbuf_load is the one handshake-qualified exception).
  always_comb begin
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    s_ready       = 1'b0;
    lbuf_word_idx = '0;
    m_valid       = 1'b0;
    m_tlast       = 1'b0;
    obuf_load     = 1'b0;
    obuf_word_idx = '0;
    bram_en       = 1'b0;
    bram_we       = 1'b0;
    bram_addr     = '0;
    case (state)
      S_WR_FILL: begin
        s_ready       = 1'b1;
        lbuf_word_idx = cnt;
      end
      S_WR_COMMIT: begin
        bram_en   = 1'b1;
        bram_we   = 1'b1;
        bram_addr = addr;
      end
      S_RD_ISSUE: begin
        bram_en   = 1'b1;
        bram_addr = addr;
      end
      S_RD_WAIT: obuf_load = (lat == LAT_LAST);
      S_RD_DRAIN: begin
        m_valid       = 1'b1;
        obuf_word_idx = cnt;
        m_tlast       = (cnt == LAST_IDX) && (addr == bound);
      end
      default: ;
    endcase
  end

  assign lbuf_load = s_valid & s_ready;

endmodule

// File: tb/tb_axis_bram_adapter_v2_0_cntl.sv
// Testbench for axis_bram_adapter_v2_0_cntl: directed and randomized write
// and read transfers, compared against a transaction-level model derived
// from the line range, words per line and read latency.

module tb_axis_bram_adapter_v2_0_cntl;

  localparam int AW  = 3;
  localparam int W   = 4;
  localparam int IW  = 2;
  localparam int LAT = 2;
  localparam int AMASK = (1 << AW) - 1;
`ifdef AXIS_BRAM_ADAPTER_IN_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rw;
  logic [AW-1:0] start_index;
  logic [AW-1:0] bound_index;
  logic          busy;
  logic          done;
  logic          s_valid;
  logic          s_ready;
  logic          s_tlast;
  logic          lbuf_load;
  logic [IW-1:0] lbuf_word_idx;
  logic          m_valid;
  logic          m_ready;
  logic          m_tlast;
  logic          obuf_load;
  logic [IW-1:0] obuf_word_idx;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;

  int vecs = 0;
  int miss = 0;

  axis_bram_adapter_v2_0_cntl #(
    .ADDR_W(AW), .WORDS_PER_LINE(W), .IDX_W(IW), .BRAM_RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw),
    .start_index(start_index), .bound_index(bound_index),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_tlast(s_tlast),
    .lbuf_load(lbuf_load), .lbuf_word_idx(lbuf_word_idx),
    .m_valid(m_valid), .m_ready(m_ready), .m_tlast(m_tlast),
    .obuf_load(obuf_load), .obuf_word_idx(obuf_word_idx),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; rw = 1'b0; start_index = '0; bound_index = '0;
    s_valid = 1'b0; s_tlast = 1'b0; m_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_srdy"},  int'(s_ready), 0);
    chk({tag, "_lload"}, int'(lbuf_load), 0);
    chk({tag, "_lidx"},  int'(lbuf_word_idx), 0);
    chk({tag, "_mval"},  int'(m_valid), 0);
    chk({tag, "_mlast"}, int'(m_tlast), 0);
    chk({tag, "_oload"}, int'(obuf_load), 0);
    chk({tag, "_oidx"},  int'(obuf_word_idx), 0);
    chk({tag, "_en"},    int'(bram_en), 0);
    chk({tag, "_we"},    int'(bram_we), 0);
    chk({tag, "_addr"},  int'(bram_addr), 0);
  endtask

  // Write transfer. tlast_beat >= 0 marks the (0-based) beat carrying s_tlast.
  task automatic run_write(input int sa, input int ba, input bit stall,
                           input int tlast_beat, input bit stray);
    int  q_idx[$];
    int  q_addr[$];
    int  dones = 0, busy_cyc = 0, cyc = 0, beats = 0;
    int  nl, exp_lines, exp_beats;
    bit  fin = 1'b0;
    nl        = ((ba - sa) & AMASK) + 1;
    exp_lines = nl;
    exp_beats = nl * W;
    if (TLAST_EN && tlast_beat >= 0 && tlast_beat < nl * W) begin
      exp_lines = tlast_beat / W + 1;
      exp_beats = tlast_beat + 1;
    end
    start = 1'b1; rw = 1'b1; start_index = AW'(sa); bound_index = AW'(ba);
    #1;
    chk("wr_busy_at_start", int'(busy), 0);
    tick();
    start = 1'b0; rw = 1'b0;
    chk("wr_busy_after_start", int'(busy), 1);
    while (!fin && cyc < 400) begin
      s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tlast_beat >= 0) s_tlast = (beats == tlast_beat);
      else s_tlast = TLAST_EN ? 1'b0 : 1'($urandom_range(0, 1));
      if (stray && cyc == 2) begin
        start = 1'b1; rw = 1'b0; start_index = AW'(~sa); bound_index = AW'(sa);
      end else begin
        start = 1'b0;
      end
      #1;
      if (lbuf_load) begin
        q_idx.push_back(int'(lbuf_word_idx));
        beats++;
      end
      if (bram_en) begin
        q_addr.push_back(int'(bram_addr));
        chk("wr_commit_we", int'(bram_we), 1);
        chk("wr_commit_srdy", int'(s_ready), 0);
      end
      if (done) dones++;
      else if (busy) busy_cyc++;
      if (!busy) fin = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    start = 1'b0; s_valid = 1'b0; s_tlast = 1'b0;
    chk("wr_finished", int'(fin), 1);
    chk("wr_idle_srdy", int'(s_ready), 0);
    chk("wr_beats", q_idx.size(), exp_beats);
    for (int i = 0; i < q_idx.size() && i < exp_beats; i++)
      chk("wr_word_idx", q_idx[i], i % W);
    chk("wr_commits", q_addr.size(), exp_lines);
    for (int i = 0; i < q_addr.size() && i < exp_lines; i++)
      chk("wr_commit_addr", q_addr[i], (sa + i) & AMASK);
    chk("wr_done_pulses", dones, 1);
    if (!stall) chk("wr_busy_cycles", busy_cyc, exp_beats + exp_lines);
  endtask

  task automatic run_read(input int sa, input int ba, input bit stall);
    int  q_idx[$];
    int  q_last[$];
    int  q_addr[$];
    int  q_iss[$];
    int  q_ld[$];
    int  dones = 0, busy_cyc = 0, cyc = 0, nl, total;
    int  prev_idx = 0;
    bit  prev_hold = 1'b0;
    bit  fin = 1'b0;
    nl    = ((ba - sa) & AMASK) + 1;
    total = nl * W;
    start = 1'b1; rw = 1'b0; start_index = AW'(sa); bound_index = AW'(ba);
    tick();
    start = 1'b0;
    chk("rd_busy_after_start", int'(busy), 1);
    while (!fin && cyc < 400) begin
      m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_hold) begin
        chk("rd_hold_valid", int'(m_valid), 1);
        chk("rd_hold_idx", int'(obuf_word_idx), prev_idx);
      end
      prev_hold = m_valid && !m_ready;
      prev_idx  = int'(obuf_word_idx);
      if (m_valid && m_ready) begin
        q_idx.push_back(int'(obuf_word_idx));
        q_last.push_back(int'(m_tlast));
      end
      if (bram_en) begin
        q_addr.push_back(int'(bram_addr));
        q_iss.push_back(cyc);
        chk("rd_issue_we", int'(bram_we), 0);
      end
      if (obuf_load) q_ld.push_back(cyc);
      if (done) dones++;
      else if (busy) busy_cyc++;
      if (!busy) fin = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    m_ready = 1'b0;
    chk("rd_finished", int'(fin), 1);
    chk("rd_beats", q_idx.size(), total);
    for (int i = 0; i < q_idx.size() && i < total; i++) begin
      chk("rd_word_idx", q_idx[i], i % W);
      chk("rd_tlast", q_last[i], (i == total - 1) ? 1 : 0);
    end
    chk("rd_issues", q_addr.size(), nl);
    chk("rd_loads", q_ld.size(), nl);
    for (int i = 0; i < q_addr.size() && i < nl; i++) begin
      chk("rd_issue_addr", q_addr[i], (sa + i) & AMASK);
      if (i < q_ld.size()) chk("rd_load_latency", q_ld[i] - q_iss[i], LAT);
    end
    chk("rd_done_pulses", dones, 1);
    if (!stall) chk("rd_busy_cycles", busy_cyc, nl * (1 + LAT + W));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(busy), 0);

    // Directed full-rate transfers over lines 5..6
    run_write(5, 6, 1'b0, -1, 1'b0);
    run_read(5, 6, 1'b0);
    run_read(5, 6, 1'b1);
    // Address wrap through 0
    run_write(6, 1, 1'b0, -1, 1'b0);
    run_read(7, 0, 1'b0);
    // start while busy is ignored
    run_write(2, 3, 1'b0, -1, 1'b1);

    // Reset in the middle of WR_FILL with two words already taken
    start = 1'b1; rw = 1'b1; start_index = 3'd2; bound_index = 3'd4;
    tick();
    start = 1'b0; rw = 1'b0; s_valid = 1'b1;
    tick();
    tick();
    chk("pre_reset_idx", int'(lbuf_word_idx), 2);
    rst = 1'b1; m_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midreset");
    tick();
    chk("midreset_still_idle", int'(busy), 0);
    s_valid = 1'b0; m_ready = 1'b0;
    run_write(3, 3, 1'b0, -1, 1'b0);

`ifdef AXIS_BRAM_ADAPTER_IN_TLAST_EN
    // tlast on the second beat of line 5 ends the transfer after one commit
    run_write(5, 1, 1'b0, 1, 1'b0);
    tick();
    chk("tlast_no_srdy", int'(s_ready), 0);
`endif

    // Randomized transfers with random stalls
    for (int k = 0; k < 8; k++) begin
      int sa, ba;
      bit st;
      sa = int'($urandom_range(0, AMASK));
      ba = int'($urandom_range(0, AMASK));
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) run_write(sa, ba, st, -1, 1'b0);
      else run_read(sa, ba, st);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
